// File: rtl/risc_controller.sv
// risc_controller: eight-phase VeriRISC instruction sequencer.
// Phase counter plus opcode decode into datapath strobes.
module risc_controller #(
    parameter logic HALT_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic [2:0] phase
);

    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    logic halted;
    logic aluop;
    logic is_hlt;
    logic is_jmp;

    assign aluop  = (opcode == ADD) || (opcode == AND) ||
                    (opcode == XOR) || (opcode == LDA);
    assign is_hlt = (opcode == HLT);
    assign is_jmp = (opcode == JMP);

    // Phase advances every clock; a HLT in OP_ADDR may freeze it there.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase  <= INST_ADDR;
            halted <= 1'b0;
        end else if (halted) begin
            phase  <= phase;
        end else if (HALT_STICKY && phase == OP_ADDR && is_hlt) begin
            halted <= 1'b1;
        end else begin
            phase  <= phase + 3'd1;
        end
    end

    // Strobe decode from registered phase, halted flag, opcode and zero.
    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_FETCH: begin
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    mem_rd = aluop;
                end
                ALU_OP: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = is_jmp;
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = is_jmp;
                    load_pc = is_jmp;
                    mem_wr  = (opcode == STO);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: scoreboard bench for both halt modes.
// Two instances run in lockstep on shared stimulus.
module tb_risc_controller;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero;

    logic       mem_rd_s, load_ir_s, halt_s, inc_pc_s;
    logic       load_ac_s, load_pc_s, mem_wr_s;
    logic [2:0] phase_s;
    logic       mem_rd_n, load_ir_n, halt_n, inc_pc_n;
    logic       load_ac_n, load_pc_n, mem_wr_n;
    logic [2:0] phase_n;

    logic [9:0] obs_s;
    logic [9:0] obs_n;
    logic [9:0] es;
    logic [9:0] en;
    logic [9:0] q_s[$];
    logic [9:0] q_n[$];

    // model state: {halted, phase}
    logic [3:0] st_s;
    logic [3:0] st_n;

    int n_cmp;
    int n_bad;

    risc_controller #(.HALT_STICKY(1'b1)) u_sticky (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd_s), .load_ir(load_ir_s), .halt(halt_s),
        .inc_pc(inc_pc_s), .load_ac(load_ac_s), .load_pc(load_pc_s),
        .mem_wr(mem_wr_s), .phase(phase_s)
    );

    risc_controller #(.HALT_STICKY(1'b0)) u_pulse (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_rd(mem_rd_n), .load_ir(load_ir_n), .halt(halt_n),
        .inc_pc(inc_pc_n), .load_ac(load_ac_n), .load_pc(load_pc_n),
        .mem_wr(mem_wr_n), .phase(phase_n)
    );

    assign obs_s = {phase_s, mem_rd_s, load_ir_s, halt_s, inc_pc_s,
                    load_ac_s, load_pc_s, mem_wr_s};
    assign obs_n = {phase_n, mem_rd_n, load_ir_n, halt_n, inc_pc_n,
                    load_ac_n, load_pc_n, mem_wr_n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
    function automatic logic [9:0] model_out(input logic [3:0] st,
                                             input logic [2:0] op,
                                             input logic z);
        logic [2:0] ph;
        logic alu;
        logic [6:0] s;
        ph  = st[2:0];
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        s   = 7'b0;
        if (st[3]) begin
            s = 7'b0010000;
        end else begin
            case (ph)
                3'd1: s = 7'b1000000;
                3'd2: s = 7'b1100000;
                3'd3: s = 7'b1100000;
                3'd4: s = {2'b00, op == HLT, 1'b1, 3'b000};
                3'd5: s = {alu, 6'b0};
                3'd6: s = {alu, 2'b00, (op == SKZ) && z, alu, op == JMP, 1'b0};
                3'd7: s = {alu, 2'b00, op == JMP, alu, op == JMP, op == STO};
                default: s = 7'b0;
            endcase
        end
        return {ph, s};
    endfunction

    function automatic logic [3:0] nxt(input logic [3:0] st,
                                       input logic sticky,
                                       input logic [2:0] op,
                                       input logic r);
        if (!r) return 4'b0;
        if (st[3]) return st;
        if (sticky && st[2:0] == 3'd4 && op == HLT) return {1'b1, st[2:0]};
        return {1'b0, st[2:0] + 3'd1};
    endfunction

    // One clock: advance both models, clock the DUTs, push expectations.
    task automatic tick();
        st_s = nxt(st_s, 1'b1, opcode, rst_);
        st_n = nxt(st_n, 1'b0, opcode, rst_);
        @(posedge clk);
        #1;
        q_s.push_back(model_out(st_s, opcode, zero));
        q_n.push_back(model_out(st_n, opcode, zero));
    endtask

    // Assert reset between edges; expectations pushed for the async response.
    task automatic pulse_reset_start();
        #2;
        rst_ = 1'b0;
        st_s = 4'b0;
        st_n = 4'b0;
        #1;
        q_s.push_back(model_out(st_s, opcode, zero));
        q_n.push_back(model_out(st_n, opcode, zero));
    endtask

    task automatic test_reset();
        rst_   = 1'b0;
        opcode = ADD;
        zero   = 1'b0;
        st_s   = 4'b0;
        st_n   = 4'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            es = q_s.pop_front();
            en = q_n.pop_front();
            n_cmp++;
            if ({obs_s, obs_n} !== {es, en}) begin
                n_bad++;
                $display("FAIL reset: got %h/%h want %h/%h",
                         obs_s, obs_n, es, en);
            end
        end
        rst_ = 1'b1;
    endtask

    task automatic test_add();
        opcode = ADD;
        for (int i = 0; i < 8; i++) begin
            tick();
            es = q_s.pop_front();
            en = q_n.pop_front();
            n_cmp++;
            if ({obs_s, obs_n} !== {es, en}) begin
                n_bad++;
                $display("FAIL add c%0d: got %h/%h want %h/%h",
                         i, obs_s, obs_n, es, en);
            end
        end
    endtask

    task automatic test_skz();
        opcode = SKZ;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            for (int i = 0; i < 8; i++) begin
                tick();
                es = q_s.pop_front();
                en = q_n.pop_front();
                n_cmp++;
                if ({obs_s, obs_n} !== {es, en}) begin
                    n_bad++;
                    $display("FAIL skz z%0d c%0d: got %h/%h want %h/%h",
                             zero, i, obs_s, obs_n, es, en);
                end
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jmp_sto();
        logic [2:0] ops [2];
        ops[0] = JMP;
        ops[1] = STO;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 8; i++) begin
                tick();
                es = q_s.pop_front();
                en = q_n.pop_front();
                n_cmp++;
                if ({obs_s, obs_n} !== {es, en}) begin
                    n_bad++;
                    $display("FAIL jmp_sto op%0d c%0d: got %h/%h want %h/%h",
                             opcode, i, obs_s, obs_n, es, en);
                end
            end
        end
    endtask

    // Opcode and zero change every cycle, including mid-instruction.
    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) begin
            opcode = 3'($urandom_range(1, 7));
            zero   = 1'($urandom_range(0, 1));
            tick();
            es = q_s.pop_front();
            en = q_n.pop_front();
            n_cmp++;
            if ({obs_s, obs_n} !== {es, en}) begin
                n_bad++;
                $display("FAIL b2b c%0d op%0d: got %h/%h want %h/%h",
                         i, opcode, obs_s, obs_n, es, en);
            end
        end
        for (int i = 0; i < 8 && st_s[2:0] != 3'd7; i++) tick();
        tick();
        q_s.delete();
        q_n.delete();
    endtask

    task automatic test_reset_mid();
        opcode = LDA;
        for (int i = 0; i < 8 && st_s[2:0] != 3'd5; i++) begin
            tick();
            void'(q_s.pop_front());
            void'(q_n.pop_front());
        end
        n_cmp++;
        if (phase_s !== 3'd5) begin
            n_bad++;
            $display("FAIL reset_mid reach: got %0d want 5", phase_s);
        end
        pulse_reset_start();
        es = q_s.pop_front();
        en = q_n.pop_front();
        n_cmp++;
        if ({obs_s, obs_n} !== {es, en}) begin
            n_bad++;
            $display("FAIL reset_mid async: got %h/%h want %h/%h",
                     obs_s, obs_n, es, en);
        end
        rst_ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            es = q_s.pop_front();
            en = q_n.pop_front();
            n_cmp++;
            if ({obs_s, obs_n} !== {es, en}) begin
                n_bad++;
                $display("FAIL reset_mid seq c%0d: got %h/%h want %h/%h",
                         i, obs_s, obs_n, es, en);
            end
        end
    endtask

    task automatic test_halt_sticky();
        opcode = HLT;
        for (int i = 0; i < 5; i++) begin
            tick();
            es = q_s.pop_front();
            en = q_n.pop_front();
            n_cmp++;
            if ({obs_s, obs_n} !== {es, en}) begin
                n_bad++;
                $display("FAIL halt_sticky c%0d: got %h/%h want %h/%h",
                         i, obs_s, obs_n, es, en);
            end
        end
        opcode = ADD;
        for (int i = 0; i < 20; i++) begin
            tick();
            es = q_s.pop_front();
            en = q_n.pop_front();
            n_cmp++;
            if ({obs_s, obs_n} !== {es, en}) begin
                n_bad++;
                $display("FAIL halt_hold c%0d: got %h/%h want %h/%h",
                         i, obs_s, obs_n, es, en);
            end
        end
        pulse_reset_start();
        es = q_s.pop_front();
        en = q_n.pop_front();
        n_cmp++;
        if ({obs_s, obs_n} !== {es, en}) begin
            n_bad++;
            $display("FAIL halt_reset: got %h/%h want %h/%h",
                     obs_s, obs_n, es, en);
        end
        rst_ = 1'b1;
    endtask

    task automatic test_halt_pulse();
        opcode = HLT;
        for (int i = 0; i < 8; i++) begin
            tick();
            es = q_s.pop_front();
            en = q_n.pop_front();
            n_cmp++;
            if ({obs_s, obs_n} !== {es, en}) begin
                n_bad++;
                $display("FAIL halt_pulse c%0d: got %h/%h want %h/%h",
                         i, obs_s, obs_n, es, en);
            end
        end
        n_cmp++;
        if (phase_n !== 3'd0 || halt_n !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_pulse wrap: got ph%0d h%0d want ph0 h0",
                     phase_n, halt_n);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_skz();
        test_jmp_sto();
        test_back_to_back();
        test_reset_mid();
        test_halt_sticky();
        test_halt_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
